// File: rtl/mem_refill_arbiter.sv
// Arbitrates one 128-bit main-memory port between I-cache line refills and MEM-stage data accesses.
// Define MEMARB_STATS_EN to add the ofill_cnt / ostall_cnt statistics outputs.
module mem_refill_arbiter #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         icache_miss,
    input  logic [31:0]  icache_addr,
    input  logic         dmem_req,
    input  logic         dmem_we,
    input  logic [31:0]  dmem_addr,
    input  logic [31:0]  dmem_wdata,
    output logic [31:0]  mem_addr,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic [31:0]  mem_wdata,
    output logic [3:0]   mem_wmask,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [127:0] oline,
    output logic         oline_valid,
    output logic [31:0]  odmem_rdata,
    output logic         odmem_done,
    output logic         oupdatepc,
`ifdef MEMARB_STATS_EN
    output logic [31:0]  ofill_cnt,
    output logic [31:0]  ostall_cnt,
`endif
    output logic         oerr
);

    typedef enum logic [2:0] {IDLE, IFILL, DACC, IRESP, DRESP} state_t;
    typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        word_sel_q, word_sel_d;
    logic              is_store_q, is_store_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [127:0]      oline_q, oline_d;
    logic              oline_valid_q, oline_valid_d;
    logic [31:0]       odmem_rdata_q, odmem_rdata_d;
    logic              odmem_done_q, odmem_done_d;
    logic              oerr_q, oerr_d;

    logic              grant_data;
    logic              timeout;
    logic [31:0]       ready_word;

    // Low address bits are implied by line alignment and word alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{icache_addr[3:0], dmem_addr[1:0]};

    always_comb begin
        ready_word = mem_rdata[31:0];
        case (word_sel_q)
            2'd1:    ready_word = mem_rdata[63:32];
            2'd2:    ready_word = mem_rdata[95:64];
            2'd3:    ready_word = mem_rdata[127:96];
            default: ready_word = mem_rdata[31:0];
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wait_d        = wait_q;
        word_sel_d    = word_sel_q;
        is_store_d    = is_store_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        oline_d       = oline_q;
        oline_valid_d = 1'b0;
        odmem_rdata_d = odmem_rdata_q;
        odmem_done_d  = 1'b0;
        oerr_d        = oerr_q;

        // Data wins a collision unless it was the last requester served.
        grant_data = dmem_req && (!icache_miss || last_grant_q == GRANT_INSTR);
        timeout    = (wait_q == WAIT_LAST);

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (grant_data) begin
                    state_d      = DACC;
                    last_grant_d = GRANT_DATA;
                    mem_addr_d   = {dmem_addr[31:4], 4'b0000};
                    word_sel_d   = dmem_addr[3:2];
                    is_store_d   = dmem_we;
                    mem_rd_d     = !dmem_we;
                    mem_wr_d     = dmem_we;
                    if (dmem_we) begin
                        mem_wdata_d = dmem_wdata;
                        mem_wmask_d = 4'b0001 << dmem_addr[3:2];
                    end else begin
                        mem_wmask_d = 4'b0000;
                    end
                end else if (icache_miss) begin
                    state_d      = IFILL;
                    last_grant_d = GRANT_INSTR;
                    mem_addr_d   = {icache_addr[31:4], 4'b0000};
                    mem_rd_d     = 1'b1;
                    mem_wr_d     = 1'b0;
                end
            end
            IFILL, DACC: begin
                if (mem_ready || timeout) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    wait_d   = '0;
                    if (!mem_ready) begin
                        oerr_d = 1'b1;
                    end
                    if (state_q == IFILL) begin
                        state_d       = IRESP;
                        oline_valid_d = 1'b1;
                        oline_d       = mem_ready ? mem_rdata : '0;
                    end else begin
                        state_d      = DRESP;
                        odmem_done_d = 1'b1;
                        if (!mem_ready) begin
                            odmem_rdata_d = '0;
                        end else if (!is_store_q) begin
                            odmem_rdata_d = ready_word;
                        end
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            IRESP, DRESP: state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Fetch may advance only when no refill is pending and any data access is finishing.
    assign oupdatepc = !icache_miss && (state_q == IDLE || state_q == DRESP) &&
                       (!dmem_req || odmem_done_q);

`ifdef MEMARB_STATS_EN
    logic [31:0] fill_cnt_q, fill_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fill_cnt_d  = fill_cnt_q + {31'd0, oline_valid_q};
        stall_cnt_d = stall_cnt_q + {31'd0, (!oupdatepc && icache_miss)};
    end

    assign ofill_cnt  = fill_cnt_q;
    assign ostall_cnt = stall_cnt_q;
`endif

    // NOTE: sequential state uses nonblocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_INSTR;
            wait_q        <= '0;
            word_sel_q    <= 2'd0;
            is_store_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
            oline_q       <= '0;
            oline_valid_q <= 1'b0;
            odmem_rdata_q <= '0;
            odmem_done_q  <= 1'b0;
            oerr_q        <= 1'b0;
`ifdef MEMARB_STATS_EN
            fill_cnt_q    <= '0;
            stall_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wait_q        <= wait_d;
            word_sel_q    <= word_sel_d;
            is_store_q    <= is_store_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wmask_q   <= mem_wmask_d;
            oline_q       <= oline_d;
            oline_valid_q <= oline_valid_d;
            odmem_rdata_q <= odmem_rdata_d;
            odmem_done_q  <= odmem_done_d;
            oerr_q        <= oerr_d;
`ifdef MEMARB_STATS_EN
            fill_cnt_q    <= fill_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
`endif
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wmask   = mem_wmask_q;
    assign oline       = oline_q;
    assign oline_valid = oline_valid_q;
    assign odmem_rdata = odmem_rdata_q;
    assign odmem_done  = odmem_done_q;
    assign oerr        = oerr_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: directed cases then random transactions against a
// timeline model (grant order, strobe windows, response pulses, sticky error).
`timescale 1ns/1ps
module tb_mem_refill_arbiter;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned WAIT_W   = 3;

    logic         clk = 1'b0;
    logic         rstn;
    logic         icache_miss;
    logic [31:0]  icache_addr;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic [31:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wmask;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [127:0] oline;
    logic         oline_valid;
    logic [31:0]  odmem_rdata;
    logic         odmem_done;
    logic         oupdatepc;
    logic         oerr;
`ifdef MEMARB_STATS_EN
    logic [31:0]  ofill_cnt;
    logic [31:0]  ostall_cnt;
`endif

    always #5 clk = ~clk;

    mem_refill_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .clk(clk), .rstn(rstn),
        .icache_miss(icache_miss), .icache_addr(icache_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .oline(oline), .oline_valid(oline_valid),
        .odmem_rdata(odmem_rdata), .odmem_done(odmem_done),
        .oupdatepc(oupdatepc),
`ifdef MEMARB_STATS_EN
        .ofill_cnt(ofill_cnt), .ostall_cnt(ostall_cnt),
`endif
        .oerr(oerr)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    bit          last_data_m;
    bit          err_m;
    int unsigned fill_m;
    int unsigned stall_m;

    // Every cycle the cache reports a miss at the edge is a stall cycle.
    always @(posedge clk) begin
        if (!rstn) stall_m <= 0;
        else if (icache_miss) stall_m <= stall_m + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef MEMARB_STATS_EN
        check("ofill_cnt", ofill_cnt, fill_m);
        check("ostall_cnt", ostall_cnt, stall_m);
`endif
    endtask

    // Called at posedge+1 of a cycle in which the DUT is idle; returns likewise.
    task automatic run_scn(input bit want_i, input bit want_d, input bit we,
                           input logic [31:0] iaddr, input logic [31:0] daddr,
                           input logic [31:0] wdata, input int lat_i, input int lat_d,
                           input logic [127:0] line_i, input logic [127:0] line_d);
        bit           kd[2];
        bit           tmo[2];
        int           st[2];
        int           rs[2];
        int           n, s, lat, last_c, act, rsp;
        bit           exp_rd, exp_wr, is_iresp, is_dresp, is_idle, exp_pc;
        logic [127:0] sh;

        n = 0;
        kd[0] = 1'b0;
        kd[1] = 1'b0;
        if (want_i && want_d) begin
            kd[0] = !last_data_m;
            kd[1] = last_data_m;
            n = 2;
        end else if (want_d) begin
            kd[0] = 1'b1;
            n = 1;
        end else if (want_i) begin
            n = 1;
        end
        s = 1;
        for (int k = 0; k < n; k++) begin
            lat    = kd[k] ? lat_d : lat_i;
            tmo[k] = lat >= int'(MAX_WAIT);
            st[k]  = s;
            rs[k]  = s + (tmo[k] ? int'(MAX_WAIT) : lat + 1);
            s      = rs[k] + 2;
            last_data_m = kd[k];
        end
        last_c = (n == 0) ? 1 : rs[n-1] + 1;
        sh = line_d >> (32 * int'(daddr[3:2]));

        icache_miss = want_i;
        icache_addr = iaddr;
        dmem_req    = want_d;
        dmem_we     = we;
        dmem_addr   = daddr;
        dmem_wdata  = wdata;
        mem_ready   = 1'($urandom);
        mem_rdata   = {4{$urandom}};
        #1;
        check("oupdatepc_c0", oupdatepc, !want_i && !want_d);

        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            act = -1;
            rsp = -1;
            for (int k = 0; k < n; k++) begin
                if (c >= st[k] && c < rs[k]) act = k;
                if (c == rs[k]) rsp = k;
            end
            is_iresp = (rsp >= 0) && !kd[rsp >= 0 ? rsp : 0];
            is_dresp = (rsp >= 0) && kd[rsp >= 0 ? rsp : 0];
            is_idle  = (act < 0) && (rsp < 0);
            exp_rd   = (act >= 0) && (!kd[act >= 0 ? act : 0] || !we);
            exp_wr   = (act >= 0) && kd[act >= 0 ? act : 0] && we;

            check("mem_rd", mem_rd, exp_rd);
            check("mem_wr", mem_wr, exp_wr);
            if (act >= 0) begin
                check("mem_addr", mem_addr,
                      kd[act] ? {daddr[31:4], 4'h0} : {iaddr[31:4], 4'h0});
                if (exp_wr) begin
                    check("mem_wdata", mem_wdata, wdata);
                    check("mem_wmask", mem_wmask, 4'b0001 << daddr[3:2]);
                end
            end
            if (rsp >= 0 && tmo[rsp]) err_m = 1'b1;
            check("oline_valid", oline_valid, is_iresp);
            check("odmem_done", odmem_done, is_dresp);
            check("oerr", oerr, err_m);
            if (is_iresp) begin
                check("oline", oline, tmo[rsp] ? 128'd0 : line_i);
                fill_m++;
                icache_miss = 1'b0;
            end
            if (is_dresp) begin
                if (!we) check("odmem_rdata", odmem_rdata, tmo[rsp] ? 32'd0 : sh[31:0]);
                dmem_req = 1'b0;
            end
            if (c == last_c) check_stats();

            if (act >= 0) begin
                mem_rdata = kd[act] ? line_d : line_i;
                mem_ready = !tmo[act] && (c == rs[act] - 1);
            end else begin
                mem_rdata = {4{$urandom}};
                mem_ready = 1'($urandom);
            end
            #1;
            exp_pc = !icache_miss && (is_idle || is_dresp) && (!dmem_req || is_dresp);
            check("oupdatepc", oupdatepc, exp_pc);
        end
    endtask

    task automatic check_reset_state();
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wmask", mem_wmask, 4'd0);
        check("rst_oline", oline, 128'd0);
        check("rst_oline_valid", oline_valid, 1'b0);
        check("rst_odmem_rdata", odmem_rdata, 32'd0);
        check("rst_odmem_done", odmem_done, 1'b0);
        check("rst_oerr", oerr, 1'b0);
        check_stats();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] line;
        logic [31:0]  ia, da, wd;
        int           kind;

        rstn        = 1'b0;
        icache_miss = 1'b0;
        icache_addr = '0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        mem_rdata   = '0;
        mem_ready   = 1'b0;
        last_data_m = 1'b0;
        err_m       = 1'b0;
        fill_m      = 0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rstn = 1'b1;
        #1;
        check("rst_oupdatepc", oupdatepc, 1'b1);

        // Collision straight after reset: data first, then instruction; repeated.
        run_scn(1, 1, 0, 32'h0000_2000, 32'h0000_0104, 0, 0, 1,
                {4{32'hA5A5_0001}}, {32'h4, 32'h3, 32'h2, 32'h1});
        run_scn(1, 1, 1, 32'h0000_2010, 32'h0000_0108, 32'hCAFE_F00D, 1, 0,
                {4{32'h5A5A_0002}}, 128'd0);

        // Refill with ready three cycles after the read strobe.
        run_scn(1, 0, 0, 32'h0000_1234, 0, 0, 3, 0,
                {32'h0303_0303, 32'h0202_0202, 32'h0101_0101, 32'h0000_0000}, 128'd0);

        // Load of word 2.
        run_scn(0, 1, 0, 0, 32'h0000_0048, 0, 0, 1,
                0, {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333});

        // Store to word 3.
        run_scn(0, 1, 1, 0, 32'h0000_004C, 32'h1234_5678, 0, 2, 0, {4{32'h7777_7777}});

        // Timeouts: ready never arrives.
        run_scn(1, 0, 0, 32'h0000_3000, 0, 0, 99, 0, {4{32'hFFFF_FFFF}}, 0);
        run_scn(0, 1, 0, 0, 32'h0000_3004, 0, 0, 99, 0, {4{32'hEEEE_EEEE}});

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            ia   = $urandom & 32'hFFFF_FFFC;
            da   = $urandom & 32'hFFFF_FFFC;
            wd   = $urandom;
            line = {$urandom, $urandom, $urandom, $urandom};
            run_scn(kind != 1, kind != 0, 1'($urandom), ia, da, wd,
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    line, {$urandom, $urandom, $urandom, $urandom});
        end

        // Reset in the middle of a refill wait.
        icache_miss = 1'b1;
        icache_addr = 32'h0000_4444;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_strobe", mem_rd, 1'b1);
        @(posedge clk);
        #1;
        rstn        = 1'b0;
        icache_miss = 1'b0;
        @(posedge clk);
        #1;
        last_data_m = 1'b0;
        err_m       = 1'b0;
        fill_m      = 0;
        check_reset_state();
        rstn      = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rstmid_oupdatepc", oupdatepc, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rstmid_no_valid", oline_valid, 1'b0);
            check("rstmid_no_rd", mem_rd, 1'b0);
        end
        mem_ready = 1'b0;

        // Round robin restarts with data first.
        run_scn(1, 1, 0, 32'h0000_5000, 32'h0000_500C, 0, 2, 0,
                {4{32'h1357_9BDF}}, {32'h0BAD_F00D, 96'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Sequences the shared 128-bit main-memory port between two requesters.
- Requester 1: instruction-cache line refills on a fetch miss.
- Requester 2: single-word data loads/stores from the MEM stage.
- Drives the PC-update enable so fetch stalls while a refill is outstanding, and returns refill lines on the cache's memory-input bus.

Parameters:
- MAX_WAIT, 255: cycles a memory access may wait for mem_ready before timing out.
- WAIT_W, 8: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  synchronous active-low reset.
- icache_miss  input  1  instruction cache reports a miss for icache_addr.
- icache_addr  input  32  current PC.
- dmem_req  input  1  data access request; held until odmem_done.
- dmem_we  input  1  1 = store, 0 = load.
- dmem_addr  input  32  data byte address, word aligned.
- dmem_wdata  input  32  store data.
- mem_addr  output  32  address to main memory.
- mem_rd  output  1  read strobe.
- mem_wr  output  1  write strobe.
- mem_wdata  output  32  store data to memory.
- mem_wmask  output  4  one-hot word-lane select for stores.
- mem_rdata  input  128  line returned by memory.
- mem_ready  input  1  memory completes the current access this cycle.
- oline  output  128  refill line to the instruction cache memory-input bus.
- oline_valid  output  1  one-cycle pulse: oline is valid.
- odmem_rdata  output  32  load result.
- odmem_done  output  1  one-cycle pulse: data access complete.
- oupdatepc  output  1  PC register update enable.
- oerr  output  1  sticky timeout flag.

Behaviour:
- States: IDLE, IFILL, DACC, IRESP, DRESP.
- Every output except oupdatepc is registered.
- Reset (rstn=0 at an edge):
  - state=IDLE, last_grant=INSTR.
  - mem_rd=mem_wr=0; mem_addr, mem_wdata, mem_wmask, oline, odmem_rdata = 0.
  - oline_valid=odmem_done=oerr=0; wait counter=0.
  - Reset mid-access abandons the access; strobes are low after that edge.
- IDLE arbitration:
  - Only one requester pending: grant it.
  - Both pending: grant the one not in last_grant (round robin). After reset, data wins first.
  - Grant instruction: go to IFILL; mem_addr={icache_addr[31:4],4'b0}; mem_rd=1.
  - Grant data: go to DACC; mem_addr={dmem_addr[31:4],4'b0}.
    - Load: mem_rd=1.
    - Store: mem_wr=1, mem_wdata=dmem_wdata, mem_wmask bit dmem_addr[3:2] set.
  - Update last_grant on every grant.
- IFILL / DACC:
  - Hold strobes and address stable until mem_ready=1.
  - On mem_ready: drop strobes next edge and go to IRESP/DRESP.
  - IFILL on ready: oline<=mem_rdata.
  - DACC load on ready: odmem_rdata<=mem_rdata word[dmem_addr[3:2]] (word 0 = bits 31:0).
- IRESP: oline_valid=1 for exactly this cycle; next state IDLE.
- DRESP: odmem_done=1 for exactly this cycle; next state IDLE.
- No grant is made in IRESP/DRESP. This gives the cache one cycle to write the line and clear its miss.
- Minimum latency: request in cycle 0, strobe high in cycle 1, mem_ready in cycle 1, response pulse in cycle 2, next grant possible in cycle 3.
- Timeout:
  - The wait counter increments each IFILL/DACC cycle with mem_ready=0 and clears on state entry.
  - When it reaches MAX_WAIT: drop strobes, set oerr (sticky until reset), go to the response state.
  - Response data on timeout: oline=0 or odmem_rdata=0.
- oupdatepc = 1 only when icache_miss=0, state is IDLE/DRESP, and dmem_req=0 or odmem_done=1. This is combinational from state and inputs. 0 during any refill.
- mem_ready outside IFILL/DACC is ignored.
- A request dropped mid-access does not abort the access; the access completes normally.

Optional Feature:
- Macro: MEMARB_STATS_EN.
- Defined: adds outputs ofill_cnt[31:0] and ostall_cnt[31:0], both reset to 0.
  - ofill_cnt increments on each oline_valid pulse.
  - ostall_cnt increments on every cycle with oupdatepc=0 and icache_miss=1.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Refill with mem_ready 3 cycles after mem_rd, icache_addr=0x0000_1234:
  - mem_addr=0x0000_1230.
  - oline_valid pulses one cycle later with oline=mem_rdata.
  - oupdatepc=0 throughout.
- Load, dmem_addr=0x0000_0048, mem_rdata word2=0xDEAD_BEEF: odmem_rdata=0xDEADBEEF, odmem_done for one cycle, mem_wr never high.
- Store, dmem_addr=0x0000_004C, wdata=0x1234_5678: mem_wr=1, mem_wmask=4'b1000, mem_wdata=0x12345678 held until mem_ready.
- icache_miss and dmem_req together after reset: data is granted first, instruction next. Repeat the collision: grants alternate.
- MAX_WAIT=4, mem_ready never asserted:
  - Strobes drop after 4 wait cycles.
  - oerr=1 and stays 1 through further traffic.
  - oline=0 with an oline_valid pulse.
- rstn=0 during IFILL wait: mem_rd=0 and state IDLE after that edge; oline_valid never pulses; with MEMARB_STATS_EN, counters read 0.
